key_entry_ctrl: RTL and testbench

//   Sequencer between the matrix-keypad scanner and the seven-segment / beeper outputs.

---
 rtl/key_entry_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_key_entry_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_ctrl.sv
// Keypad entry sequencer: builds a 6-digit BCD entry from scanner key events,
// drives the seven-segment display word/enables, commits values and times beeps.
module key_entry_ctrl #(
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned BEEP_SHORT = 5_000_000,
  parameter int unsigned BEEP_LONG  = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_num,
  input  logic        key_valid,
  output logic [23:0] disp_data,
  output logic [5:0]  disp_en,
  output logic        beep_on,
  output logic [23:0] entry_data,
  output logic        entry_valid,
  output logic        busy
);

  localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int unsigned BW = (BEEP_LONG > 0) ? $clog2(BEEP_LONG + 1) : 1;
  localparam int unsigned DW = 24;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENTRY = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  localparam logic [3:0] K_BKSP  = 4'hA;
  localparam logic [3:0] K_CLR   = 4'hB;
  localparam logic [3:0] K_ENTER = 4'hC;

  localparam logic [2:0] MAX_DIG = 3'd6;

  logic [1:0]    r_state;
  logic [DW-1:0] r_buf;
  logic [2:0]    r_cnt;
  logic [HW-1:0] r_hold;
  logic [BW-1:0] r_beep;
  logic [DW-1:0] r_entry;
  logic          r_entry_valid;
  logic [DW-1:0] r_disp_data;
  logic [5:0]    r_disp_en;
  logic          r_beep_on;
  logic          r_busy;

  logic [1:0]    w_state_nxt;
  logic [DW-1:0] w_buf_nxt;
  logic [2:0]    w_cnt_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic [BW-1:0] w_beep_nxt;
  logic [DW-1:0] w_entry_nxt;
  logic          w_commit;
  logic          w_beep_load;
  logic [BW-1:0] w_beep_len;
  logic [DW-1:0] w_disp_data_nxt;
  logic [5:0]    w_disp_en_nxt;
  logic          w_is_digit;

  assign w_is_digit = (key_num <= 4'd9);

  // Next-state, buffer, timers and beep request
  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    w_entry_nxt = r_entry;
    w_commit    = 1'b0;
    w_beep_load = 1'b0;
    w_beep_len  = '0;

    case (r_state)
      S_IDLE, S_ENTRY: begin
        if (key_valid) begin
          if (w_is_digit) begin
            if (r_cnt < MAX_DIG) begin
              w_buf_nxt   = {r_buf[19:0], key_num};
              w_cnt_nxt   = r_cnt + 3'd1;
              w_state_nxt = S_ENTRY;
              w_beep_load = 1'b1;
              w_beep_len  = BW'(BEEP_SHORT);
            end else begin
              w_state_nxt = S_ERR;
              w_hold_nxt  = HW'(HOLD_CYC - 1);
              w_beep_load = 1'b1;
              w_beep_len  = BW'(BEEP_LONG);
            end
          end else if (key_num == K_BKSP) begin
            if (r_cnt != 3'd0) begin
              w_buf_nxt   = {4'h0, r_buf[23:4]};
              w_cnt_nxt   = r_cnt - 3'd1;
              w_state_nxt = (r_cnt == 3'd1) ? S_IDLE : S_ENTRY;
              w_beep_load = 1'b1;
              w_beep_len  = BW'(BEEP_SHORT);
            end
          end else if (key_num == K_CLR) begin
            w_buf_nxt   = '0;
            w_cnt_nxt   = 3'd0;
            w_hold_nxt  = '0;
            w_state_nxt = S_IDLE;
            w_beep_load = 1'b1;
            w_beep_len  = BW'(BEEP_SHORT);
          end else if (key_num == K_ENTER) begin
            if (r_cnt != 3'd0) begin
              w_entry_nxt = r_buf;
              w_commit    = 1'b1;
              w_state_nxt = S_HOLD;
            end else begin
              w_state_nxt = S_ERR;
            end
            w_hold_nxt  = HW'(HOLD_CYC - 1);
            w_beep_load = 1'b1;
            w_beep_len  = BW'(BEEP_LONG);
          end
        end
      end
      default: begin
        // HOLD / ERR: only clear is honoured; otherwise run the hold timer
        if (key_valid && (key_num == K_CLR)) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = 3'd0;
          w_hold_nxt  = '0;
          w_state_nxt = S_IDLE;
          w_beep_load = 1'b1;
          w_beep_len  = BW'(BEEP_SHORT);
        end else if (r_hold == '0) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_hold_nxt  = r_hold - HW'(1);
        end
      end
    endcase

    if (w_beep_load) begin
      w_beep_nxt = w_beep_len;
    end else if (r_beep != '0) begin
      w_beep_nxt = r_beep - BW'(1);
    end else begin
      w_beep_nxt = r_beep;
    end
  end

  // Display word and digit enables follow the state being entered
  always_comb begin
    w_disp_data_nxt = '0;
    w_disp_en_nxt   = 6'b000000;
    case (w_state_nxt)
      S_ENTRY: begin
        w_disp_data_nxt = w_buf_nxt;
        for (int i = 0; i < 6; i++) begin
          w_disp_en_nxt[i] = (3'(i) < w_cnt_nxt);
        end
      end
      S_HOLD: begin
        w_disp_data_nxt = w_entry_nxt;
        w_disp_en_nxt   = 6'b111111;
      end
      S_ERR: begin
        w_disp_data_nxt = 24'hEEEEEE;
        w_disp_en_nxt   = 6'b111111;
      end
      default: begin
        w_disp_data_nxt = '0;
        w_disp_en_nxt   = 6'b000000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_buf         <= '0;
      r_cnt         <= 3'd0;
      r_hold        <= '0;
      r_beep        <= '0;
      r_entry       <= '0;
      r_entry_valid <= 1'b0;
      r_disp_data   <= '0;
      r_disp_en     <= 6'b000000;
      r_beep_on     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_buf         <= w_buf_nxt;
      r_cnt         <= w_cnt_nxt;
      r_hold        <= w_hold_nxt;
      r_beep        <= w_beep_nxt;
      r_entry       <= w_entry_nxt;
      r_entry_valid <= w_commit;
      r_disp_data   <= w_disp_data_nxt;
      r_disp_en     <= w_disp_en_nxt;
      r_beep_on     <= (w_beep_nxt != '0);
      r_busy        <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_ERR);
    end
  end

  assign disp_data   = r_disp_data;
  assign disp_en     = r_disp_en;
  assign beep_on     = r_beep_on;
  assign entry_data  = r_entry;
  assign entry_valid = r_entry_valid;
  assign busy        = r_busy;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Scoreboard bench for key_entry_ctrl: a digit-queue reference model predicts
// every output each cycle; a monitor on the falling edge pops and compares.
module tb_key_entry_ctrl;

  localparam int HOLD  = 20;
  localparam int SHORT = 3;
  localparam int LONG  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_num;
  logic        key_valid;
  logic [23:0] disp_data;
  logic [5:0]  disp_en;
  logic        beep_on;
  logic [23:0] entry_data;
  logic        entry_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  key_entry_ctrl #(
    .HOLD_CYC  (HOLD),
    .BEEP_SHORT(SHORT),
    .BEEP_LONG (LONG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_num    (key_num),
    .key_valid  (key_valid),
    .disp_data  (disp_data),
    .disp_en    (disp_en),
    .beep_on    (beep_on),
    .entry_data (entry_data),
    .entry_valid(entry_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] dd;
    logic [5:0]  en;
    logic        beep;
    logic [23:0] ed;
    logic        ev;
    logic        busy;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] entry_q[$];

  // Reference model state: typed digits (oldest first), busy countdown, beep countdown
  int          m_digits[$];
  int          m_hold_left = 0;
  bit          m_err = 1'b0;
  logic [23:0] m_committed = '0;
  int          m_beep_left = 0;

  function automatic logic [23:0] pack_digits();
    logic [23:0] v = '0;
    foreach (m_digits[i]) v = (v << 4) | 24'(m_digits[i]);
    return v;
  endfunction

  task automatic model_clear();
    m_digits.delete();
    m_hold_left = 0;
    m_err = 1'b0;
  endtask

  always @(posedge clk) begin
    bit   ev;
    int   len;
    int   k;
    exp_t e;
    ev  = 1'b0;
    len = 0;
    k   = int'(key_num);
    if (rst) begin
      model_clear();
      m_committed = '0;
      m_beep_left = 0;
    end else begin
      if (m_hold_left > 0) begin
        if (key_valid && k == 11) begin
          model_clear();
          len = SHORT;
        end else if (m_hold_left == 1) begin
          model_clear();
        end else begin
          m_hold_left--;
        end
      end else if (key_valid) begin
        if (k <= 9) begin
          if (m_digits.size() < 6) begin
            m_digits.push_back(k);
            len = SHORT;
          end else begin
            m_err = 1'b1;
            m_hold_left = HOLD;
            len = LONG;
          end
        end else if (k == 10) begin
          if (m_digits.size() > 0) begin
            void'(m_digits.pop_back());
            len = SHORT;
          end
        end else if (k == 11) begin
          model_clear();
          len = SHORT;
        end else if (k == 12) begin
          m_hold_left = HOLD;
          len = LONG;
          if (m_digits.size() > 0) begin
            m_committed = pack_digits();
            ev = 1'b1;
            m_err = 1'b0;
            entry_q.push_back(m_committed);
          end else begin
            m_err = 1'b1;
          end
        end
      end
      if (len > 0) m_beep_left = len;
      else if (m_beep_left > 0) m_beep_left--;
    end

    e.busy = (m_hold_left > 0);
    if (m_hold_left > 0) begin
      e.dd = m_err ? 24'hEEEEEE : m_committed;
      e.en = 6'b111111;
    end else begin
      e.dd = pack_digits();
      e.en = 6'((1 << m_digits.size()) - 1);
    end
    e.beep = (m_beep_left != 0);
    e.ed   = m_committed;
    e.ev   = ev;
    exp_q.push_back(e);
  end

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compare every presented output cycle against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("disp_data",   disp_data,          e.dd);
      chk("disp_en",     24'(disp_en),       24'(e.en));
      chk("beep_on",     24'(beep_on),       24'(e.beep));
      chk("entry_data",  entry_data,         e.ed);
      chk("entry_valid", 24'(entry_valid),   24'(e.ev));
      chk("busy",        24'(busy),          24'(e.busy));
    end
    if (entry_valid === 1'b1) begin
      if (entry_q.size() == 0) chk("commit_unexpected", entry_data, 24'hXXXXXX);
      else chk("commit_value", entry_data, entry_q.pop_front());
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [3:0] k);
    rst = r;
    key_valid = v;
    key_num = k;
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [3:0] k);
    cyc(1'b0, 1'b1, k);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    rst = 1'b1;
    key_valid = 1'b0;
    key_num = 4'h0;
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0);

    // Three digits with full beeps between them
    for (int d = 1; d <= 3; d++) begin press(4'(d)); idle(4); end
    press(4'hB); idle(4);

    // Backspace down to empty, then one extra backspace
    for (int d = 1; d <= 3; d++) press(4'(d));
    press(4'hA); idle(2);
    for (int i = 0; i < 3; i++) begin press(4'hA); idle(4); end

    // Seventh digit overflows into the error display
    for (int d = 1; d <= 7; d++) press(4'(d));
    idle(HOLD + 5);

    // Commit and a dropped key during hold
    press(4'h4); press(4'h5); press(4'hC); idle(3);
    press(4'h9); idle(HOLD);

    // Empty enter, clear out of error, D/E/F everywhere
    press(4'hC); idle(4); press(4'hB); idle(4);
    press(4'hD); press(4'h1); press(4'hE); press(4'hC); press(4'hF); idle(2);
    press(4'hB); press(4'hC); press(4'hD); idle(HOLD + 2);

    // Reset during hold while beeping
    press(4'h4); press(4'h5); press(4'hC); idle(1);
    cyc(1'b1, 1'b0, 4'h0); idle(3);

    // Randomized key traffic
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [3:0] k;
      r = $urandom_range(0, 199);
      if ($urandom_range(0, 3) == 0) k = 4'($urandom_range(10, 15));
      else k = 4'($urandom_range(0, 9));
      if (r < 1) cyc(1'b1, 1'b0, 4'h0);
      else if (r < 90) press(k);
      else cyc(1'b0, 1'b0, 4'($urandom_range(0, 15)));
    end

    idle(2);
    @(negedge clk);
    #1;
    chk("pending_commits", 24'(entry_q.size()), 24'd0);
    chk("pending_expect",  24'(exp_q.size()),   24'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
